// File: rtl/mem_arbiter_if.sv
// Bus bundle joining the core's fetch and data ports, the memory arbiter and the
// single-port word memory. Addresses use big-endian bit numbering (bit 0 = MSB).
interface mem_arbiter_if #(
    parameter int MEMORY_DEPTH = 32768
);
    localparam int ADDR_W = $clog2(MEMORY_DEPTH);

    logic              if_req;
    logic [0:31]       if_addr;
    logic              if_ack;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic [0:31]       d_addr;
    logic [3:0]        d_wen;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_wen;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wen, d_wdata, mem_read_data,
        output if_ack, if_rvalid, if_rdata, if_err,
        output d_ack, d_rvalid, d_rdata, d_err,
        output mem_address, mem_wen, mem_write_data
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wen, d_wdata, mem_read_data,
        input  if_ack, if_rvalid, if_rdata, if_err,
        input  d_ack, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_wen, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port synchronous-read word memory, with starvation guard.
// Optional grant/conflict counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
    parameter int MEMORY_DEPTH = 32768,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]  perf_if_grants,
    output logic [31:0]  perf_d_grants,
    output logic [31:0]  perf_conflicts
`endif
);
    localparam int         ADDR_W = $clog2(MEMORY_DEPTH);
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Count cycles fetch waited while requesting; any grant or idle fetch clears it.
    function automatic logic [3:0] starve_step(input logic [3:0] cnt,
                                               input logic       req,
                                               input logic       won);
        if (!req || won)    return 4'd0;
        if (cnt >= LIMIT)   return LIMIT;
        return cnt + 4'd1;
    endfunction

    logic [ADDR_W-1:0] if_word;
    logic [ADDR_W-1:0] d_word;
    logic              if_oor;
    logic              d_oor;
    logic              d_is_write;
    logic              grant_if;
    logic              grant_d;

    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_valid_q, rd_valid_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              rd_err_q, rd_err_d;

    logic              fetch_resp;
    logic              data_resp;

    // Byte-offset bits are never used: only aligned word accesses exist.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.if_addr[30:31], bus.d_addr[30:31]};

    always_comb begin
        if_word    = bus.if_addr[30-ADDR_W:29];
        d_word     = bus.d_addr[30-ADDR_W:29];
        if_oor     = |bus.if_addr[0:29-ADDR_W];
        d_oor      = |bus.d_addr[0:29-ADDR_W];
        d_is_write = |bus.d_wen;
    end

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!rst) begin
            if (bus.d_req && !(bus.if_req && starve_q == LIMIT)) begin
                grant_d = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d           = starve_step(starve_q, bus.if_req, grant_if);
        addr_d             = addr_q;
        bus.mem_wen        = 4'b0000;
        bus.mem_write_data = 32'h0;
        if (grant_d) begin
            addr_d             = d_word;
            bus.mem_write_data = bus.d_wdata;
            if (!d_oor) begin
                bus.mem_wen = bus.d_wen;
            end
        end else if (grant_if) begin
            addr_d = if_word;
        end
        bus.mem_address = addr_d;
    end

    always_comb begin
        rd_valid_d = grant_if || (grant_d && !d_is_write);
        rd_owner_d = grant_d ? OWN_DATA : OWN_FETCH;
        rd_err_d   = grant_d ? d_oor : if_oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= 4'd0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= OWN_FETCH;
            rd_err_q   <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Response stage: read data arrives one cycle after the grant and goes to its owner only.
    assign fetch_resp = rd_valid_q && (rd_owner_q == OWN_FETCH);
    assign data_resp  = rd_valid_q && (rd_owner_q == OWN_DATA);

    assign bus.if_ack    = grant_if;
    assign bus.if_rvalid = fetch_resp;
    assign bus.if_rdata  = (fetch_resp && !rd_err_q) ? bus.mem_read_data : 32'h0;
    assign bus.if_err    = fetch_resp && rd_err_q;

    assign bus.d_ack     = grant_d;
    assign bus.d_rvalid  = data_resp;
    assign bus.d_rdata   = (data_resp && !rd_err_q) ? bus.mem_read_data : 32'h0;
    assign bus.d_err     = (data_resp && rd_err_q) || (grant_d && d_is_write && d_oor);

`ifdef MEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_if_d   = grant_if ? sat_inc32(perf_if_q) : perf_if_q;
        perf_d_d    = grant_d ? sat_inc32(perf_d_q) : perf_d_q;
        perf_conf_d = (bus.if_req && bus.d_req) ? sat_inc32(perf_conf_q) : perf_conf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_q   <= 32'h0;
            perf_d_q    <= 32'h0;
            perf_conf_q <= 32'h0;
        end else begin
            perf_if_q   <= perf_if_d;
            perf_d_q    <= perf_d_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_conf_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a behavioural model of the arbitration rules.
module tb_mem_arbiter;
    localparam int DEPTH  = 32768;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LIMIT  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEMORY_DEPTH(DEPTH)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

    mem_arbiter #(.MEMORY_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants (perf_if_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    // Synchronous-read memory; lane k of mem_wen is the byte at address+k (big-endian).
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] mem_rdata;
    logic        bd_we;
    logic [31:0] bd_addr;
    logic [31:0] bd_data;
    assign bus.mem_read_data = mem_rdata;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr[ADDR_W-1:0]] <= bd_data;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.mem_wen[k])
                    mem[bus.mem_address][8*(3-k) +: 8] <= bus.mem_write_data[8*(3-k) +: 8];
            end
        end
        mem_rdata <= mem[bus.mem_address];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic check_all(input string tag,
                             input logic e_ifack, input logic e_dack,
                             input logic [31:0] e_maddr, input logic [3:0] e_mwen,
                             input logic e_ifrv, input logic [31:0] e_ifrd, input logic e_iferr,
                             input logic e_drv, input logic [31:0] e_drd, input logic e_derr);
        chk({tag, " if_ack"},    32'(bus.if_ack),      32'(e_ifack));
        chk({tag, " d_ack"},     32'(bus.d_ack),       32'(e_dack));
        chk({tag, " mem_addr"},  32'(bus.mem_address), e_maddr);
        chk({tag, " mem_wen"},   32'(bus.mem_wen),     32'(e_mwen));
        chk({tag, " if_rvalid"}, 32'(bus.if_rvalid),   32'(e_ifrv));
        chk({tag, " if_rdata"},  bus.if_rdata,         e_ifrd);
        chk({tag, " if_err"},    32'(bus.if_err),      32'(e_iferr));
        chk({tag, " d_rvalid"},  32'(bus.d_rvalid),    32'(e_drv));
        chk({tag, " d_rdata"},   bus.d_rdata,          e_drd);
        chk({tag, " d_err"},     32'(bus.d_err),       32'(e_derr));
    endtask

    task automatic set_in(input logic ifr, input logic [31:0] ifa, input logic dr,
                          input logic [31:0] da, input logic [3:0] wen, input logic [31:0] wd);
        bus.if_req  = ifr;
        bus.if_addr = ifa;
        bus.d_req   = dr;
        bus.d_addr  = da;
        bus.d_wen   = wen;
        bus.d_wdata = wd;
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr,
                         input logic [31:0] da, input logic [3:0] wen, input logic [31:0] wd);
        @(negedge clk);
        set_in(ifr, ifa, dr, da, wen, wd);
        #1;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 32'(w); bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ifr;   logic [31:0] ifa;
        logic        dr;    logic [31:0] da;  logic [3:0] wen; logic [31:0] wd;
        logic        e_ifack; logic e_dack; logic [31:0] e_maddr; logic [3:0] e_mwen;
        logic        e_ifrv; logic [31:0] e_ifrd; logic e_iferr;
        logic        e_drv;  logic [31:0] e_drd;  logic e_derr;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h8000_0000 | ($urandom_range(0, 63) << 2);
        if (r == 1) return (32'd1 << $urandom_range(17, 31)) | ($urandom_range(0, 63) << 2);
        return ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
    endfunction

    // Behavioural model state for the randomized run.
    logic [31:0] ref_mem [0:63];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          starve_m;
        logic [31:0] last_m;
        logic        pv, powner, perr;
        logic [31:0] pdata;
        logic        if_pend, d_pend;
        logic [31:0] if_a, d_a, d_wd, wdv;
        logic [3:0]  d_w, e_mwen;
        logic        e_if, e_d, if_oor, d_oor;
        int          if_w, d_w_idx;
        logic [31:0] e_maddr;

        rst = 1'b1;
        bd_we = 1'b0; bd_addr = 32'h0; bd_data = 32'h0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);

        preload(0,    32'h0123_4567);
        preload(16,   32'hDEAD_BEEF);
        preload(17,   32'hCAFE_F00D);
        preload(32,   32'hAAAA_AAAA);

        // Requests during reset must not be acknowledged.
        drive(1'b1, 32'h40, 1'b1, 32'h80, 4'hF, 32'hFFFF_FFFF);
        check_all("reset", 0, 0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;

        tbl[0]  = '{1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b1, 1'b0, 32'h10, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 1'b1, 32'h80, 4'b0110, 32'h1122_3344,
                    1'b0, 1'b1, 32'h20, 4'b0110, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0, 1'b1, 32'h80, 4'h0, 32'h0,
                    1'b0, 1'b1, 32'h20, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b0, 1'b0, 32'h20, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAA22_33AA, 1'b0};
        tbl[4]  = '{1'b0, 32'h0, 1'b1, 32'h0002_0000, 4'hF, 32'hFFFF_FFFF,
                    1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[5]  = '{1'b0, 32'h0, 1'b1, 32'h0002_0000, 4'h0, 32'h0,
                    1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 32'h40, 1'b1, 32'h40, 4'h0, 32'h0,
                    1'b0, 1'b1, 32'h10, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b1, 1'b0, 32'h11, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[9]  = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ifr, tbl[i].ifa, tbl[i].dr, tbl[i].da, tbl[i].wen, tbl[i].wd);
            check_all($sformatf("vec%0d", i), tbl[i].e_ifack, tbl[i].e_dack, tbl[i].e_maddr,
                      tbl[i].e_mwen, tbl[i].e_ifrv, tbl[i].e_ifrd, tbl[i].e_iferr,
                      tbl[i].e_drv, tbl[i].e_drd, tbl[i].e_derr);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("oor write left word 0", mem[0], 32'h0123_4567);
        chk("byte write merged", mem[32], 32'hAA22_33AA);

        // Continuous conflict: fetch wins every fifth cycle.
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h80, 4'h0, 32'h0);
            chk($sformatf("conflict%0d if_ack", i), 32'(bus.if_ack), 32'(i % 5 == 4));
            chk($sformatf("conflict%0d d_ack", i),  32'(bus.d_ack),  32'(i % 5 != 4));
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_conflicts", perf_conflicts, 32'd10);
        chk("perf_d_grants",  perf_d_grants,  32'd8);
        chk("perf_if_grants", perf_if_grants, 32'd2);
`endif

        // Reset while fetch is partly starved: the guard count must restart from zero.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h80, 4'h0, 32'h0);
            chk($sformatf("prestarve%0d d_ack", i), 32'(bus.d_ack), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        chk("rst drops d_rvalid", 32'(bus.d_rvalid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            #1;
            chk($sformatf("poststarve%0d if_ack", i), 32'(bus.if_ack), 32'(i == 4));
        end

        // Reset in the cycle after a fetch ack discards the response.
        drive(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("midread ack", 32'(bus.if_ack), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("midread if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("midread if_rdata", bus.if_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset if_rvalid", 32'(bus.if_rvalid), 32'd0);
        drive(1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("postreset ack", 32'(bus.if_ack), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("postreset rdata", bus.if_rdata, 32'hCAFE_F00D);

        // Randomized traffic against the behavioural model.
        reset_pulse();
        for (int w = 0; w < 64; w++) begin
            wdv = $urandom;
            ref_mem[w] = wdv;
            preload(w, wdv);
        end
        starve_m = 0; last_m = 32'h0;
        pv = 1'b0; powner = 1'b0; perr = 1'b0; pdata = 32'h0;
        if_pend = 1'b0; d_pend = 1'b0;
        if_a = 32'h0; d_a = 32'h0; d_w = 4'h0; d_wd = 32'h0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1'b1; if_a = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1; d_a = rand_addr(); d_wd = $urandom;
                d_w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            drive(if_pend, if_a, d_pend, d_a, d_w, d_wd);

            e_if    = if_pend && (!d_pend || starve_m == LIMIT);
            e_d     = d_pend && !e_if;
            if_oor  = (if_a >> (ADDR_W + 2)) != 0;
            d_oor   = (d_a >> (ADDR_W + 2)) != 0;
            if_w    = int'((if_a >> 2) % DEPTH);
            d_w_idx = int'((d_a >> 2) % DEPTH);
            e_maddr = e_d ? 32'(d_w_idx) : (e_if ? 32'(if_w) : last_m);
            e_mwen  = (e_d && !d_oor) ? d_w : 4'h0;

            check_all($sformatf("rand%0d", cyc), e_if, e_d, e_maddr, e_mwen,
                      pv && !powner, (pv && !powner) ? pdata : 32'h0, pv && !powner && perr,
                      pv && powner,  (pv && powner) ? pdata : 32'h0,
                      (pv && powner && perr) || (e_d && d_w != 0 && d_oor));

            starve_m = (!if_pend || e_if) ? 0 : ((starve_m < LIMIT) ? starve_m + 1 : LIMIT);
            last_m   = e_maddr;
            pv       = e_if || (e_d && d_w == 0);
            powner   = e_d;
            perr     = e_d ? d_oor : if_oor;
            pdata    = 32'h0;
            if (pv && !perr) pdata = ref_mem[e_d ? d_w_idx : if_w];
            if (e_d && d_w != 0 && !d_oor) begin
                for (int k = 0; k < 4; k++)
                    if (d_w[k]) ref_mem[d_w_idx][8*(3-k) +: 8] = d_wd[8*(3-k) +: 8];
            end
            if (e_if) if_pend = 1'b0;
            if (e_d)  d_pend = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
